// File: rtl/controlador_memoria_pkg.sv
// ---------------------------------------------------------------------------
// | Module      : controlador_memoria_pkg                                   |
// | Description : Shared widths, FSM encoding and latency range for the     |
// |               main-memory responder.                                    |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

package controlador_memoria_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  // Latency counter width and the range it can represent
  localparam int LAT_W       = 4;
  localparam int LATENCY_MIN = 0;
  localparam int LATENCY_MAX = 15;

  // FSM encoding
  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_WAIT   = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/controlador_memoria_banco_memoria.sv
// ---------------------------------------------------------------------------
// | Module      : banco_memoria                                             |
// | Description : Single-port synchronous RAM, DEPTH x DATA_W, registered   |
// |               read port. Logical power-up contents are mem[i]=i mod 32. |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module banco_memoria
  import controlador_memoria_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              we,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // The array stores data XOR the low address bits. A zeroed array (the
  // natural power-up state of block RAM) therefore reads back as i mod 32,
  // with no initialisation file and no reset on the storage itself.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_key;
  logic [DATA_W-1:0] w_key;

  assign w_key = addr[DATA_W-1:0];

  // Storage write port; contents survive reset
  always_ff @(posedge clock) begin
    if (we) begin
      r_mem[addr] <= din ^ w_key;
    end
  end

  // Registered read; output holds between enabled reads
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_q   <= '0;
      r_key <= '0;
    end else if (en) begin
      r_q   <= r_mem[addr];
      r_key <= w_key;
    end
  end

  assign dout = r_q ^ r_key;

endmodule

`default_nettype wire

// File: rtl/controlador_memoria.sv
// ---------------------------------------------------------------------------
// | Module      : controlador_memoria                                       |
// | Description : Main-memory responder for the associative cache. One      |
// |               fill/write-back at a time over Req/Ack, programmable      |
// |               latency, saturating transaction counters.                 |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module controlador_memoria
  import controlador_memoria_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Req,
  input  logic              C_Write_M,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] C_Block_M,
  output logic [DATA_W-1:0] M_Block_C,
  output logic              Ack,
  output logic              Busy,
  output logic [CNT_W-1:0]  Fill_Count,
  output logic [CNT_W-1:0]  WB_Count
);

  // Out-of-range latencies are clamped to what the counter can hold
  localparam int c_lat_int = (LATENCY > LATENCY_MAX) ? LATENCY_MAX :
                             ((LATENCY < LATENCY_MIN) ? LATENCY_MIN : LATENCY);
  localparam logic [LAT_W-1:0] c_lat = LAT_W'(c_lat_int);

  logic [1:0]        r_state;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_ack;
  logic              r_busy;
  logic [CNT_W-1:0]  r_fill;
  logic [CNT_W-1:0]  r_wb;
  logic              w_access;

  assign w_access = (r_state == c_ACCESS);

  // FSM, latency counter and request latches. WAIT hands over to ACCESS
  // once the counter would reach zero, so the RAM access edge lands at
  // accept edge + LATENCY + 1 (LATENCY=0 skips WAIT entirely).
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (Req) begin
            r_write <= C_Write_M;
            r_addr  <= Address;
            r_data  <= C_Block_M;
            r_cnt   <= c_lat;
            r_state <= (c_lat == '0) ? c_ACCESS : c_WAIT;
          end
        end
        c_WAIT: begin
          if (r_cnt <= LAT_W'(1)) begin
            r_cnt   <= '0;
            r_state <= c_ACCESS;
          end else begin
            r_cnt <= r_cnt - LAT_W'(1);
          end
        end
        c_ACCESS: r_state <= c_DONE;
        default:  r_state <= c_IDLE;
      endcase
    end
  end

  // Registered handshake outputs: Busy spans accept..DONE, Ack is DONE only
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_busy <= 1'b0;
      r_ack  <= 1'b0;
    end else begin
      r_ack <= w_access;
      if (r_state == c_IDLE && Req) begin
        r_busy <= 1'b1;
      end else if (r_state == c_DONE) begin
        r_busy <= 1'b0;
      end
    end
  end

  // Saturating transaction counters, bumped on the access edge
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_fill <= '0;
      r_wb   <= '0;
    end else if (w_access) begin
      if (r_write) begin
        if (r_wb != '1) r_wb <= r_wb + CNT_W'(1);
      end else begin
        if (r_fill != '1) r_fill <= r_fill + CNT_W'(1);
      end
    end
  end

  banco_memoria u_banco_memoria (
    .clock  (Clock),
    .resetn (Resetn),
    .we     (w_access & r_write),
    .en     (w_access & ~r_write),
    .addr   (r_addr),
    .din    (r_data),
    .dout   (M_Block_C)
  );

  assign Ack        = r_ack;
  assign Busy       = r_busy;
  assign Fill_Count = r_fill;
  assign WB_Count   = r_wb;

endmodule

`default_nettype wire

// File: tb/tb_controlador_memoria.sv
// ---------------------------------------------------------------------------
// | Module      : tb_controlador_memoria                                    |
// | Description : Self-checking bench for controlador_memoria against a    |
// |               transaction-level memory/counter model.                   |
// | Revision    : 1.0 - initial release                                     |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_controlador_memoria;

  localparam int L = 3;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Req, C_Write_M;
  logic [6:0] Address;
  logic [4:0] C_Block_M, M_Block_C;
  logic       Ack, Busy;
  logic [7:0] Fill_Count, WB_Count;

  // Second instance built with zero latency
  logic       z_req, z_write;
  logic [6:0] z_addr;
  logic [4:0] z_din, z_dout;
  logic       z_ack, z_busy;
  logic [7:0] z_fill, z_wb;

  always #5 Clock = ~Clock;

  controlador_memoria #(.LATENCY(L), .CNT_W(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .Req(Req), .C_Write_M(C_Write_M),
    .Address(Address), .C_Block_M(C_Block_M), .M_Block_C(M_Block_C),
    .Ack(Ack), .Busy(Busy), .Fill_Count(Fill_Count), .WB_Count(WB_Count)
  );

  controlador_memoria #(.LATENCY(0), .CNT_W(8)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .Req(z_req), .C_Write_M(z_write),
    .Address(z_addr), .C_Block_M(z_din), .M_Block_C(z_dout),
    .Ack(z_ack), .Busy(z_busy), .Fill_Count(z_fill), .WB_Count(z_wb)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: memory image, counters, last completed read value
  int model_mem [128];
  int model0_mem[128];
  int fills, wbs, last_rd;
  int fills0, wbs0, last_rd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Garbage on the request inputs while the responder is busy
  task automatic scramble();
    Address   = 7'($urandom);
    C_Block_M = 5'($urandom);
    C_Write_M = 1'($urandom);
  endtask

  // One full transaction on the LATENCY=L instance, checked every cycle
  task automatic txn(input bit wr, input int addr, input int data);
    Req = 1'b1; C_Write_M = wr; Address = 7'(addr); C_Block_M = 5'(data);
    @(posedge Clock); #1;
    Req = 1'b0; scramble();
    check("busy_accept", 32'(Busy), 1);
    check("ack_accept",  32'(Ack),  0);
    if (wr) begin
      model_mem[addr] = data % 32;
      if (wbs < 255) wbs++;
    end else begin
      last_rd = model_mem[addr];
      if (fills < 255) fills++;
    end
    for (int k = 1; k <= L; k++) begin
      @(posedge Clock); #1; scramble();
      check("ack_wait",  32'(Ack),  0);
      check("busy_wait", 32'(Busy), 1);
    end
    @(posedge Clock); #1; scramble();
    check("ack_done",  32'(Ack),       1);
    check("busy_done", 32'(Busy),      1);
    check("rd_data",   32'(M_Block_C), last_rd);
    check("fill_cnt",  32'(Fill_Count), fills);
    check("wb_cnt",    32'(WB_Count),   wbs);
    @(posedge Clock); #1;
    check("ack_idle",  32'(Ack),       0);
    check("busy_idle", 32'(Busy),      0);
    check("rd_hold",   32'(M_Block_C), last_rd);
  endtask

  // One transaction on the zero-latency instance
  task automatic txn0(input bit wr, input int addr, input int data);
    z_req = 1'b1; z_write = wr; z_addr = 7'(addr); z_din = 5'(data);
    @(posedge Clock); #1;
    z_req = 1'b0; z_addr = 7'($urandom); z_din = 5'($urandom);
    check("z_busy_accept", 32'(z_busy), 1);
    check("z_ack_accept",  32'(z_ack),  0);
    if (wr) begin
      model0_mem[addr] = data % 32;
      wbs0++;
    end else begin
      last_rd0 = model0_mem[addr];
      fills0++;
    end
    @(posedge Clock); #1;
    check("z_ack_done", 32'(z_ack),  1);
    check("z_rd_data",  32'(z_dout), last_rd0);
    @(posedge Clock); #1;
    check("z_ack_idle",  32'(z_ack),  0);
    check("z_busy_idle", 32'(z_busy), 0);
    check("z_fill_cnt",  32'(z_fill), fills0);
    check("z_wb_cnt",    32'(z_wb),   wbs0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int pool[4];
    pool = '{100, 101, 102, 103};
    for (int i = 0; i < 128; i++) begin
      model_mem[i]  = i % 32;
      model0_mem[i] = i % 32;
    end
    fills = 0; wbs = 0; last_rd = 0;
    fills0 = 0; wbs0 = 0; last_rd0 = 0;

    Resetn = 1'b0; Req = 1'b0; C_Write_M = 1'b0; Address = '0; C_Block_M = '0;
    z_req = 1'b0; z_write = 1'b0; z_addr = '0; z_din = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_ack",  32'(Ack),        0);
    check("rst_busy", 32'(Busy),       0);
    check("rst_data", 32'(M_Block_C),  0);
    check("rst_fill", 32'(Fill_Count), 0);
    check("rst_wb",   32'(WB_Count),   0);
    Resetn = 1'b1;
    @(posedge Clock); #1;

    // Basic fill, write-back and read-after-write
    txn(1'b0, 100, 0);
    txn(1'b1, 102, 5'b10110);
    txn(1'b0, 102, 0);

    // Req held high: one transaction every L+3 cycles
    Req = 1'b1; C_Write_M = 1'b0; Address = 7'd5;
    for (int e = 0; e <= (L + 1) + 2 * (L + 3); e++) begin
      bit exp_ack, exp_busy;
      @(posedge Clock); #1;
      exp_ack  = (e >= L + 1) && (((e - (L + 1)) % (L + 3)) == 0);
      exp_busy = !((e >= L + 2) && (((e - (L + 2)) % (L + 3)) == 0));
      check("held_ack",  32'(Ack),  32'(exp_ack));
      check("held_busy", 32'(Busy), 32'(exp_busy));
      if (exp_ack) begin
        if (fills < 255) fills++;
        last_rd = model_mem[5];
        check("held_data", 32'(M_Block_C), last_rd);
        check("held_fill", 32'(Fill_Count), fills);
      end
    end
    Req = 1'b0;
    @(posedge Clock); #1;
    check("held_end_busy", 32'(Busy), 0);
    check("held_end_ack",  32'(Ack),  0);

    // Reset during WAIT of a write to 33 aborts it
    Req = 1'b1; C_Write_M = 1'b1; Address = 7'd33; C_Block_M = 5'd0;
    @(posedge Clock); #1;
    Req = 1'b0;
    @(posedge Clock); #1;
    Resetn = 1'b0;
    #2;
    check("abort_busy", 32'(Busy), 0);
    check("abort_ack",  32'(Ack),  0);
    @(posedge Clock); #1;
    Resetn = 1'b1;
    fills = 0; wbs = 0; last_rd = 0;
    for (int k = 0; k < L + 3; k++) begin
      @(posedge Clock); #1;
      check("abort_no_ack", 32'(Ack), 0);
    end
    check("abort_wb",   32'(WB_Count),   0);
    check("abort_fill", 32'(Fill_Count), 0);
    txn(1'b0, 33, 0);

    // Randomised mix; the small pool forces read-after-write hits
    for (int i = 0; i < 40; i++) begin
      int a;
      a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)] : int'($urandom_range(0, 127));
      txn(1'($urandom_range(0, 1)), a, int'($urandom_range(0, 31)));
    end

    // Enough reads to saturate Fill_Count
    for (int i = 0; i < 300; i++) begin
      txn(1'b0, int'($urandom_range(0, 127)), 0);
    end
    check("fill_saturated", 32'(Fill_Count), 255);

    // Zero-latency instance
    txn0(1'b0, 100, 0);
    txn0(1'b1, 9, 17);
    txn0(1'b0, 9, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
